cmos_spi_master: RTL
====================

Name: cmos_spi_master

Overview:
- Serialises one CMOS-sensor register command onto the sensor's 4-wire SPI port per start strobe.
- Sits between the register-sequence generator and the sensor pins.
- Consumes a 10-bit command_address word (bits [9:1] register address, bit [0] 1=write / 0=read) and a 16-bit data word.
- Returns read-back data for read commands.

Parameters:
- CLK_DIV, 4: clk_in cycles per SCLK half-period; legal range 1..255.
- CMD_W, 10: command_address width (address plus R/W bit).
- DATA_W, 16: data/read-back width.

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  request strobe; accepted only when busy=0
- command_address  input  10  [9:1] register address, [0] write enable
- data  input  16  write payload; ignored for reads
- busy  output  1  high from accept until the done cycle
- done  output  1  one-cycle pulse at end of frame
- rd_data  output  16  last read-back word
- spi_cs_n  output  1  chip select, active low
- spi_sclk  output  1  serial clock, idle low
- spi_mosi  output  1  serial data to sensor, MSB first
- spi_miso  input  1  serial data from sensor

Behaviour:
- Reset (reset=0 at a clk_in edge): state IDLE, busy=0, done=0, rd_data=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, all counters 0.
- Frame: 26 bits, MSB first: command_address[9:0] then 16 data bits.
  - Write: mosi carries data[15:0].
  - Read: mosi=0 during the data bits; miso sampled.
- Sensor samples mosi on SCLK rise. Block changes mosi only while SCLK is low (at the fall). Block samples miso on its own SCLK rise.
- Inputs are latched into a 26-bit shift register and an R/W flag on the accepting edge. Later input changes have no effect on the frame in flight.
- States:
  - IDLE: start=1 → SETUP. On the same edge: busy=1, cs_n=0, mosi=command_address[9].
  - SETUP: hold D=CLK_DIV cycles with sclk=0 → SHIFT.
  - SHIFT: 26 SCLK periods, each D cycles high then D cycles low.
    - sclk rises at the start of each high phase.
    - At each fall, shift the next bit onto mosi.
    - For a read, on rise of bits 10..25, shift miso into a 16-bit capture register.
    - After the 26th low phase → HOLD.
  - HOLD: D cycles, cs_n=0, sclk=0, mosi=0 → GAP. On that edge: cs_n=1.
  - GAP: D cycles with cs_n=1 → DONE.
  - DONE: one cycle.
    - done=1, busy=0.
    - For a read, rd_data ← capture register on the DONE-entry edge, so it is valid in the same cycle done=1. Writes leave rd_data unchanged.
    - Next edge → IDLE.
- Latency: counting the accepting edge as edge 0, done is high after edge 55·D (D=4 → 220). busy is high for exactly 55·D cycles.
- Minimum cs_n-high time between frames: D+2 cycles (GAP, DONE, IDLE). start held high continuously starts a new frame on the first IDLE edge after DONE.
- start during busy (SETUP..GAP) or in the DONE cycle: ignored, not queued.
- Reset mid-frame: next edge forces the reset values. cs_n=1 and sclk=0 immediately; no done pulse; the partial capture is discarded.
- Half-period counter is 8 bits; bit counter is 5 bits (0..25, no wrap beyond 25).

Test Plan:
1. CLK_DIV=4, write cmd=10'b0000000101, data=16'h0001 → mosi at the 26 rises = 0000000101_0000000000000001; 26 sclk rises; done after edge 220; rd_data stays 0.
2. Read cmd=10'b0000100010, miso model returns 16'hA5C3 on bits 10..25 → mosi data bits all 0; rd_data=16'hA5C3 in the done cycle; a subsequent write leaves it at 16'hA5C3.
3. Pulse start at edges 5, 50 and 219 of a frame begun at edge 0 → exactly one frame; no extra cs_n fall; a single done.
4. Assert reset=0 at the 12th sclk rise of a read → cs_n=1 and sclk=0 after the next edge; busy=0; done never pulses; rd_data=0.
5. start held high, CLK_DIV=1 → sclk period 2 clk_in cycles; done every 55+2 cycles; cs_n high exactly 3 cycles between frames.
6. Change command_address/data every cycle during a frame → serialized bits equal the values present on the accepting edge.

Source files
------------

// File: rtl/cmos_spi_master.sv
// CMOS sensor SPI master: serialises one 26-bit register command per start
// strobe (MSB first) and returns the 16-bit read-back word for read commands.
module cmos_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CMD_W   = 10,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic [CMD_W-1:0]  command_address,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned FRAME_W = CMD_W + DATA_W;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 5;

    localparam logic [CNT_W-1:0] HALF_LAST      = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT       = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] FIRST_DATA_BIT = BIT_W'(CMD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  shreg_q, shreg_d;
    logic                rd_flag_q, rd_flag_d;
    logic [DATA_W-1:0]   capture_q, capture_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;

    logic                half_end;
    logic [BIT_W-1:0]    next_bit;

    assign half_end = (cnt_q == HALF_LAST);
    assign next_bit = bit_cnt_q + BIT_W'(1);

    // Next-state and output logic; every phase lasts CLK_DIV cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rd_flag_d = rd_flag_q;
        capture_d = capture_q;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        if (state_q inside {S_SETUP, S_SHIFT, S_HOLD, S_GAP}) begin
            cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETUP;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    capture_d = '0;
                    rd_flag_d = ~command_address[0];
                    // Read frames carry zeros in the data field.
                    shreg_d   = {command_address,
                                 (command_address[0] ? data : {DATA_W{1'b0}})};
                    mosi_d    = command_address[CMD_W-1];
                end
            end
            S_SETUP: begin
                if (half_end) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (half_end) begin
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                        mosi_d  = shreg_q[FRAME_W-2];
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = next_bit;
                        if (rd_flag_q && (next_bit >= FIRST_DATA_BIT)) begin
                            capture_d = {capture_q[DATA_W-2:0], spi_miso};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (half_end) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (half_end) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (rd_flag_q) begin
                        rd_data_d = capture_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rd_flag_q <= 1'b0;
            capture_q <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rd_flag_q <= rd_flag_d;
            capture_q <= capture_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule
